// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the multi-port SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} arb_state_e;

  localparam int CNT_W     = 4;
  localparam int MAX_PORTS = 8;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < MAX_PORTS; i++)
      if (oh[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Winner select (round-robin from last grant, or lowest index) plus last-grant pointer.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int RR_MODE   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 done,
  input  logic [NUM_PORTS-1:0] done_grant,
  output logic [NUM_PORTS-1:0] win,
  output logic                 any
);

  localparam int IW = $clog2(NUM_PORTS);

  logic [IW-1:0] ptr;

  always_comb begin
    logic [IW-1:0] sel;
    win = '0;
    sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel = (RR_MODE != 0) ? IW'((int'(ptr) + 1 + i) % NUM_PORTS) : IW'(i);
      if (win == '0 && req[sel]) win[sel] = 1'b1;
    end
  end

  assign any = |req;

  // Reset value points at the last port so port 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset)     ptr <= IW'(NUM_PORTS - 1);
    else if (done) ptr <= IW'(onehot_to_idx(MAX_PORTS'(done_grant)));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multi-core SRAM port arbiter: one access at a time, programmable strobe widths.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_WAIT   = 2,
  parameter int WR_WAIT   = 2,
  parameter int RR_MODE   = 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Run,
  input  logic [NUM_PORTS-1:0]        writeRequest,
  input  logic [NUM_PORTS-1:0]        readRequest,
  input  logic [NUM_PORTS*ADDR_W-1:0] ADDR,
  input  logic [NUM_PORTS*DATA_W-1:0] DATA,
  input  logic [DATA_W-1:0]           fromTristate,
  output logic [DATA_W-1:0]           toTristate,
  output logic [ADDR_W-1:0]           addressToSRAM,
  output logic                        SRAM_WE_N,
  output logic                        SRAM_OE_N,
  output logic [DATA_W-1:0]           DataToCPUs,
  output logic [NUM_PORTS-1:0]        requestDone,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        busy
);

  arb_state_e           state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_PORTS-1:0] win;
  logic                 any;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_wr;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .RR_MODE(RR_MODE)) u_arb (
    .clk        (Clk),
    .reset      (Reset),
    .req        (readRequest | writeRequest),
    .done       (state == DONE),
    .done_grant (grant),
    .win        (win),
    .any        (any)
  );

  // Winner's address/data; write takes precedence when both requests are up.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_wr   = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (win[p]) begin
        sel_addr = ADDR[p*ADDR_W +: ADDR_W];
        sel_data = DATA[p*DATA_W +: DATA_W];
        sel_wr   = writeRequest[p];
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      grant         <= '0;
      requestDone   <= '0;
      addressToSRAM <= '0;
      toTristate    <= '0;
      DataToCPUs    <= '0;
      SRAM_WE_N     <= 1'b1;
      SRAM_OE_N     <= 1'b1;
    end else begin
      requestDone <= '0;
      case (state)
        IDLE: begin
          if (Run && any) begin
            grant         <= win;
            addressToSRAM <= sel_addr;
            toTristate    <= sel_data;
            if (sel_wr) begin
              state     <= WRITE;
              SRAM_WE_N <= 1'b0;
              cnt       <= CNT_W'(WR_WAIT);
            end else begin
              state     <= READ;
              SRAM_OE_N <= 1'b0;
              cnt       <= CNT_W'(RD_WAIT);
            end
          end
        end
        READ: begin
          if (cnt == CNT_W'(1)) begin
            DataToCPUs  <= fromTristate;
            SRAM_OE_N   <= 1'b1;
            requestDone <= grant;
            state       <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WRITE: begin
          if (cnt == CNT_W'(1)) begin
            SRAM_WE_N   <= 1'b1;
            requestDone <= grant;
            state       <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin and fixed-priority instances with SRAM models.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [4:0]  wr_req, rd_req;
  logic [79:0] addr, data;

  logic [15:0] from_a, to_a, sa_a, dout_a, from_b, to_b, sa_b, dout_b;
  logic        we_n_a, oe_n_a, busy_a, we_n_b, oe_n_b, busy_b;
  logic [4:0]  done_a, grant_a, done_b, grant_b;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic        overlap = 1'b0;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_MODE(1)) u_rr (
    .Clk(clk), .Reset(reset), .Run(run), .writeRequest(wr_req), .readRequest(rd_req),
    .ADDR(addr), .DATA(data), .fromTristate(from_a), .toTristate(to_a),
    .addressToSRAM(sa_a), .SRAM_WE_N(we_n_a), .SRAM_OE_N(oe_n_a),
    .DataToCPUs(dout_a), .requestDone(done_a), .grant(grant_a), .busy(busy_a)
  );

  mem_port_arbiter #(.RR_MODE(0)) u_fx (
    .Clk(clk), .Reset(reset), .Run(run), .writeRequest(wr_req), .readRequest(rd_req),
    .ADDR(addr), .DATA(data), .fromTristate(from_b), .toTristate(to_b),
    .addressToSRAM(sa_b), .SRAM_WE_N(we_n_b), .SRAM_OE_N(oe_n_b),
    .DataToCPUs(dout_b), .requestDone(done_b), .grant(grant_b), .busy(busy_b)
  );

  always @(posedge clk) begin
    if (reset) begin
      mem_a[8'h40] <= 16'hBEEF;
      mem_b[8'h40] <= 16'hBEEF;
    end else begin
      if (!we_n_a) mem_a[sa_a[7:0]] <= to_a;
      if (!we_n_b) mem_b[sa_b[7:0]] <= to_b;
    end
  end
  assign from_a = mem_a[sa_a[7:0]];
  assign from_b = mem_b[sa_b[7:0]];

  always @(negedge clk)
    if ((!we_n_a && !oe_n_a) || (!we_n_b && !oe_n_b)) overlap <= 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [15:0] a, input logic [15:0] d);
    addr[p*16 +: 16] = a;
    data[p*16 +: 16] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] eg;
    int         rr_order [6] = '{0, 1, 3, 0, 1, 3};

    reset = 1'b1; run = 1'b0; wr_req = '0; rd_req = '0; addr = '0; data = '0;
    tick(); tick();
    chk("rst_we_n",  32'(we_n_a), 32'd1);
    chk("rst_oe_n",  32'(oe_n_a), 32'd1);
    chk("rst_addr",  32'(sa_a),   32'd0);
    chk("rst_to",    32'(to_a),   32'd0);
    chk("rst_dout",  32'(dout_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_grant", 32'(grant_a), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    reset = 1'b0; run = 1'b1;

    // Single read by port 2 at 0x0040.
    set_port(2, 16'h0040, 16'h0000); rd_req = 5'b00100;
    tick();
    chk("rd_busy",  32'(busy_a),  32'd1);
    chk("rd_grant", 32'(grant_a), 32'b00100);
    chk("rd_addr",  32'(sa_a),    32'h0040);
    chk("rd_oe1",   32'(oe_n_a),  32'd0);
    chk("rd_we1",   32'(we_n_a),  32'd1);
    tick();
    chk("rd_oe2",   32'(oe_n_a),  32'd0);
    chk("rd_nodone", 32'(done_a), 32'd0);
    tick();
    chk("rd_done",  32'(done_a),  32'b00100);
    chk("rd_oe3",   32'(oe_n_a),  32'd1);
    chk("rd_data",  32'(dout_a),  32'hBEEF);
    rd_req = '0;
    tick();
    chk("rd_idle",  32'(busy_a),  32'd0);
    chk("rd_gclr",  32'(grant_a), 32'd0);
    chk("rd_dclr",  32'(done_a),  32'd0);
    chk("rd_hold",  32'(dout_a),  32'hBEEF);

    // Port 0 writes 0x1234 to 0x0010, port 4 reads it back.
    set_port(0, 16'h0010, 16'h1234); wr_req = 5'b00001;
    tick();
    chk("wr_we1",   32'(we_n_a), 32'd0);
    chk("wr_oe1",   32'(oe_n_a), 32'd1);
    chk("wr_data",  32'(to_a),   32'h1234);
    chk("wr_addr",  32'(sa_a),   32'h0010);
    tick();
    chk("wr_we2",   32'(we_n_a), 32'd0);
    tick();
    chk("wr_we3",   32'(we_n_a), 32'd1);
    chk("wr_done",  32'(done_a), 32'b00001);
    chk("wr_hold",  32'(to_a),   32'h1234);
    wr_req = '0;
    tick();
    set_port(4, 16'h0010, 16'h0000); rd_req = 5'b10000;
    tick();
    chk("rb_grant", 32'(grant_a), 32'b10000);
    tick(); tick();
    chk("rb_done",  32'(done_a),  32'b10000);
    chk("rb_data",  32'(dout_a),  32'h1234);
    rd_req = '0;
    tick();

    // Round-robin among ports 0, 1, 3; fixed instance keeps picking port 0.
    do_reset();
    set_port(1, 16'h0041, 16'h0); set_port(3, 16'h0043, 16'h0);
    rd_req = 5'b01011;
    for (int g = 0; g < 6; g++) begin
      eg = 5'b00001 << rr_order[g];
      tick();
      chk("rr_grant", 32'(grant_a), 32'(eg));
      chk("fx_grant", 32'(grant_b), 32'b00001);
      tick(); tick();
      chk("rr_done",  32'(done_a),  32'(eg));
      tick();
    end
    rd_req = '0;

    // Fixed priority: port 0 beats port 4 until it drops.
    do_reset();
    rd_req = 5'b10001;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("fp_grant0", 32'(grant_b), 32'b00001);
      tick(); tick();
      chk("fp_done0",  32'(done_b),  32'b00001);
      if (g == 2) rd_req = 5'b10000;
      tick();
    end
    tick();
    chk("fp_grant4", 32'(grant_b), 32'b10000);
    tick(); tick();
    chk("fp_done4",  32'(done_b),  32'b10000);
    rd_req = '0;
    tick();

    // Port 1 asserts read and write together: write only.
    do_reset();
    set_port(1, 16'h0020, 16'h5555);
    rd_req = 5'b00010; wr_req = 5'b00010;
    tick();
    chk("col_we",    32'(we_n_a),  32'd0);
    chk("col_oe",    32'(oe_n_a),  32'd1);
    chk("col_grant", 32'(grant_a), 32'b00010);
    tick(); tick();
    chk("col_done",  32'(done_a),  32'b00010);
    rd_req = '0; wr_req = '0;
    tick();
    chk("col_once",  32'(done_a),  32'd0);
    chk("col_mem",   32'(mem_a[8'h20]), 32'h5555);

    // Run drops mid-write: write finishes, pending port 0 read is not granted.
    do_reset();
    set_port(3, 16'h0030, 16'hA5A5); wr_req = 5'b01000;
    tick();
    chk("run_we", 32'(we_n_a), 32'd0);
    run = 1'b0; rd_req = 5'b00001;
    tick(); tick();
    chk("run_done", 32'(done_a), 32'b01000);
    wr_req = '0;
    tick(); tick(); tick();
    chk("run_idle",  32'(busy_a),  32'd0);
    chk("run_grant", 32'(grant_a), 32'd0);
    chk("run_mem",   32'(mem_a[8'h30]), 32'hA5A5);
    rd_req = '0;

    // Reset in the second READ cycle aborts cleanly.
    run = 1'b1;
    set_port(0, 16'h0010, 16'h0); rd_req = 5'b00001;
    tick(); tick(); tick();
    chk("pre_data", 32'(dout_a), 32'h1234);
    rd_req = '0;
    tick();
    set_port(0, 16'h0040, 16'h0); rd_req = 5'b00001;
    tick(); tick();
    chk("ab_oe", 32'(oe_n_a), 32'd0);
    reset = 1'b1;
    tick();
    chk("ab_oe_n",  32'(oe_n_a),  32'd1);
    chk("ab_done",  32'(done_a),  32'd0);
    chk("ab_busy",  32'(busy_a),  32'd0);
    chk("ab_dout",  32'(dout_a),  32'd0);
    chk("ab_grant", 32'(grant_a), 32'd0);
    reset = 1'b0; rd_req = '0;
    tick();

    chk("no_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the multi-CPU SRAM IO handler.
- Arbitrates read/write requests from NUM_PORTS SLC-3 cores (port 0 = master, 1..N-1 = slaves) onto one asynchronous SRAM through the existing tristate block.
- Adds over the current handler:
  - selectable round-robin or fixed-priority arbitration
  - programmable read and write wait states
  - one-hot grant and busy outputs
  - a Run gate that holds off new grants without aborting an access in flight

Parameters:
- NUM_PORTS, 5, number of requesting cores (2..8).
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- RD_WAIT, 2, cycles SRAM_OE_N is held low per read (1..15).
- WR_WAIT, 2, cycles SRAM_WE_N is held low per write (1..15).
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority, lowest index wins.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  1 = new grants allowed; 0 = finish current access, then stay idle.
- writeRequest  in  NUM_PORTS  active-high per-port write request, level, held until requestDone.
- readRequest  in  NUM_PORTS  active-high per-port read request, level, held until requestDone.
- ADDR  in  NUM_PORTS*ADDR_W  packed per-port addresses, port p at [p*ADDR_W +: ADDR_W].
- DATA  in  NUM_PORTS*DATA_W  packed per-port write data.
- fromTristate  in  DATA_W  SRAM read data from the tristate block.
- toTristate  out  DATA_W  write data to the tristate block.
- addressToSRAM  out  ADDR_W  SRAM address.
- SRAM_WE_N  out  1  active-low write strobe; the tristate drives the bus when low.
- SRAM_OE_N  out  1  active-low output enable.
- DataToCPUs  out  DATA_W  registered read data, broadcast to all ports.
- requestDone  out  NUM_PORTS  one-cycle completion pulse to the served port.
- grant  out  NUM_PORTS  one-hot port currently owning SRAM; zero when idle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - SRAM_WE_N = SRAM_OE_N = 1
  - addressToSRAM, toTristate, DataToCPUs = 0
  - requestDone, grant = 0; busy = 0
  - state = IDLE
  - last-grant pointer = NUM_PORTS-1, so port 0 is searched first.
- A port is eligible when readRequest[p] | writeRequest[p].
- If a port asserts both, it gets a write only; the read is ignored for that grant.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If Run=1 and any port is eligible at edge k, select the winner.
  - Register grant, the winner's ADDR into addressToSRAM and its DATA into toTristate.
  - Load the wait counter; go to READ or WRITE.
  - Run=0 or no eligible port: stay in IDLE.
- READ: SRAM_OE_N=0 for exactly RD_WAIT cycles (k+1..k+RD_WAIT). On the final edge, capture fromTristate into DataToCPUs, then go to DONE.
- WRITE: SRAM_WE_N=0 for exactly WR_WAIT cycles. Address and data are stable throughout the strobe and for the following DONE cycle. Then go to DONE.
- DONE, one cycle (k+WAIT+1):
  - both strobes = 1; requestDone[granted]=1
  - DataToCPUs valid and held until the next read capture
  - update the last-grant pointer
  - next state IDLE; grant clears on leaving DONE.
- Latency:
  - idle read: request sampled at edge k gives requestDone in cycle k+RD_WAIT+1.
  - back-to-back accesses: IDLE costs 1 cycle between them.
- Round-robin (RR_MODE=1):
  - search starts at last-grant+1 mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
  - any continuously requesting port is served within NUM_PORTS grants.
- Fixed mode (RR_MODE=0): the lowest-index eligible port always wins; the pointer is ignored.
- The requester must drop its request in the cycle after requestDone. A request still high in the IDLE cycle after DONE counts as a new request.
- Request changes from non-granted ports during READ/WRITE/DONE have no effect. Changes on the granted port's request lines mid-access are ignored; the access completes.
- Run falling mid-access: the access completes, requestDone pulses, the block then stays in IDLE.
- Reset mid-access, same edge:
  - strobes return to 1, no requestDone pulse
  - DataToCPUs = 0, pointer reinitialised.
- SRAM_WE_N and SRAM_OE_N are never low in the same cycle.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, READ, WRITE, DONE)
  - 4-bit wait-counter width
  - helper function for the onehot-to-index conversion.
- Sub-module rr_arbiter (NUM_PORTS, RR_MODE): combinational winner select from the request vector and pointer, plus the registered pointer update on a done strobe.
- The FSM, datapath muxes and wait counter live in mem_port_arbiter.

Test Plan:
- Single read, defaults: port 2 read at addr 0x0040 (memory holds 0xBEEF) -> SRAM_OE_N low for 2 cycles, addressToSRAM=0x0040, requestDone=5'b00100 in cycle k+3, DataToCPUs=0xBEEF.
- Single write: port 0 writes 0x1234 to 0x0010 -> SRAM_WE_N low for 2 cycles, toTristate=0x1234; a later read of 0x0010 by port 4 returns 0x1234.
- Round-robin: ports 0, 1, 3 all request reads continuously -> grant order 0, 1, 3, 0, 1, 3; each access takes 4 cycles (IDLE + 2 wait + DONE).
- Fixed priority: RR_MODE=0, ports 0 and 4 request continuously -> port 0 always wins; port 4 is served only after port 0 drops its request.
- Collision and strobe rule: port 1 asserts read and write together -> exactly one write and one requestDone pulse; strobes are never both low.
- Run and Reset: Run dropped during a write -> the write completes and no new grant is issued. Reset asserted in the second READ cycle -> next cycle SRAM_OE_N=1, no requestDone, busy=0, DataToCPUs=0.
